// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-port request/response protocol and the
// memory responder that serves it.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int         WORD_BYTES = 4;
   localparam int         OFFS_W     = $clog2(WORD_BYTES);
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] addr_lo);
      return (addr_lo & ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: synchronous byte-lane write, combinational read.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [WORD_BYTES-1:0] wr_be,
   input  logic [AW-1:0]         addr,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (wr_be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: one request at a time, WAIT_CYCLES wait states,
// then a held response until the requester takes it.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int IDX_W = ADDR_W - OFFS_W;

   mem_state_t        state;
   logic [3:0]        wait_cnt;

   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_be;

   logic              accept;
   logic              acc_write;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_be;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_err;
   logic              commit;
   logic              ram_we;
   logic [31:0]       ram_rdata;
   logic [31:0]       load_data;

   assign accept = req_valid && req_ready && (state == IDLE);

   // With zero wait states the access commits on the accept edge, before the
   // latches hold anything, so the live request is used in IDLE.
   assign acc_write = (state == IDLE) ? req_write : lat_write;
   assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
   assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
   assign acc_be    = (state == IDLE) ? req_be    : lat_be;

   assign acc_idx   = acc_addr[ADDR_W-1:OFFS_W];
   assign acc_err   = is_misaligned(acc_addr[OFFS_W-1:0]) ||
                      (32'(acc_idx) >= 32'(DEPTH_WORDS));

   assign commit    = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == BUSY) && (wait_cnt == 4'd1));
   assign ram_we    = commit && acc_write && !acc_err;
   assign load_data = (!acc_write && !acc_err) ? ram_rdata : 32'h0;

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clock   (clock),
      .wr_en   (ram_we),
      .wr_be   (acc_be),
      .addr    (acc_idx[AW-1:0]),
      .wr_data (acc_wdata),
      .rd_data (ram_rdata)
   );

   always_ff @(posedge clock) begin
      if (accept) begin
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_be    <= req_be;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  wait_cnt  <= 4'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_data;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (wait_cnt == 4'd1) begin
                  state     <= RESP;
                  wait_cnt  <= 4'd0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= load_data;
                  rsp_err   <= acc_err;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the main
// protocol checks and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_data_mem_responder;

   logic        clock;
   logic        rst_n;

   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        z_req_valid, z_req_ready, z_req_write;
   logic [15:0] z_req_addr;
   logic [31:0] z_req_wdata;
   logic [3:0]  z_req_be;
   logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          stamp, prev, n;
   logic [31:0] zvals [3];

   data_mem_responder #(.ADDR_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   data_mem_responder #(.ADDR_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clock     (clock),
      .rst_n     (rst_n),
      .req_valid (z_req_valid),
      .req_ready (z_req_ready),
      .req_write (z_req_write),
      .req_addr  (z_req_addr),
      .req_wdata (z_req_wdata),
      .req_be    (z_req_be),
      .rsp_valid (z_rsp_valid),
      .rsp_ready (z_rsp_ready),
      .rsp_rdata (z_rsp_rdata),
      .rsp_err   (z_rsp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns just after the accepting posedge.
   task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] be);
      int k;
      k = 0;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      req_valid = 1'b1;
      while (!req_ready && k < 20) begin
         @(negedge clock);
         k++;
      end
      chk("req_ready_within_bound", 32'(k < 20), 32'd1);
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   // Counts clock edges from the accept edge until rsp_valid is seen.
   task automatic wait_rsp(output int l);
      l = 0;
      do begin
         @(negedge clock);
         l++;
      end while (!rsp_valid && l < 40);
      chk("rsp_valid_within_bound", 32'(l < 40), 32'd1);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic xact(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] r, output logic e,
                       output int l);
      issue(w, a, d, be);
      wait_rsp(l);
      r = rsp_rdata;
      e = rsp_err;
      finish_rsp();
   endtask

   initial begin
      zvals[0] = 32'h0BADF00D;
      zvals[1] = 32'h12345678;
      zvals[2] = 32'hFEEDC0DE;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
      z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0;
      z_rsp_ready = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clock);
      #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clock);

      // Test 1: store then load, latency
      xact(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, rd, er, lat);
      chk("t1_store_lat", 32'(lat), 32'd3);
      chk("t1_store_rdata", rd, 32'h0);
      chk("t1_store_err", 32'(er), 32'd0);
      xact(1'b0, 16'h0010, 32'h0, 4'h0, rd, er, lat);
      chk("t1_load_lat", 32'(lat), 32'd3);
      chk("t1_load_rdata", rd, 32'hDEADBEEF);
      chk("t1_load_err", 32'(er), 32'd0);

      // Test 2: byte-lane merge and be=0 no-op
      xact(1'b1, 16'h0020, 32'h11223344, 4'hF, rd, er, lat);
      xact(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, rd, er, lat);
      chk("t2_partial_err", 32'(er), 32'd0);
      xact(1'b0, 16'h0020, 32'h0, 4'h0, rd, er, lat);
      chk("t2_merge_rdata", rd, 32'h11BB33DD);
      xact(1'b1, 16'h0020, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
      chk("t2_be0_err", 32'(er), 32'd0);
      xact(1'b0, 16'h0020, 32'h0, 4'hF, rd, er, lat);
      chk("t2_be0_unchanged", rd, 32'h11BB33DD);

      // Test 3: misaligned and out-of-range
      xact(1'b0, 16'h0013, 32'h0, 4'hF, rd, er, lat);
      chk("t3_misalign_err", 32'(er), 32'd1);
      chk("t3_misalign_rdata", rd, 32'h0);
      xact(1'b0, 16'h0400, 32'h0, 4'hF, rd, er, lat);
      chk("t3_oor_err", 32'(er), 32'd1);
      chk("t3_oor_rdata", rd, 32'h0);
      xact(1'b1, 16'h0011, 32'h00000000, 4'hF, rd, er, lat);
      chk("t3_misalign_store_err", 32'(er), 32'd1);
      xact(1'b0, 16'h0010, 32'h0, 4'hF, rd, er, lat);
      chk("t3_word10_intact", rd, 32'hDEADBEEF);
      chk("t3_word10_err", 32'(er), 32'd0);

      // Test 4: back-pressure in RESP
      issue(1'b0, 16'h0010, 32'h0, 4'hF);
      wait_rsp(lat);
      chk("t4_lat", 32'(lat), 32'd3);
      for (int k = 0; k < 5; k++) begin
         chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t4_hold_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
      @(negedge clock);
      chk("t4_req_ready_after", 32'(req_ready), 32'd1);
      chk("t4_valid_cleared", 32'(rsp_valid), 32'd0);
      chk("t4_rdata_cleared", rsp_rdata, 32'h0);

      // Test 6: zero-wait instance, back-to-back with rsp_ready tied high
      z_req_valid = 1'b1;
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         n = 0;
         while (!z_req_ready && n < 10) begin
            @(negedge clock);
            n++;
         end
         chk("t6_ready_within_bound", 32'(n < 10), 32'd1);
         z_req_write = (i < 3);
         z_req_addr  = 16'((i % 3) * 4);
         z_req_wdata = zvals[i % 3];
         z_req_be    = 4'hF;
         @(posedge clock);
         #1 stamp = cyc;
         if (i > 0) chk("t6_interval", 32'(stamp - prev), 32'd2);
         prev = stamp;
         @(negedge clock);
         chk("t6_rsp_valid", 32'(z_rsp_valid), 32'd1);
         chk("t6_rsp_rdata", z_rsp_rdata, (i < 3) ? 32'h0 : zvals[i % 3]);
         chk("t6_rsp_err", 32'(z_rsp_err), 32'd0);
      end
      z_req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);

      // Test 5: reset during BUSY aborts an uncommitted store
      xact(1'b1, 16'h0030, 32'h01020304, 4'hF, rd, er, lat);
      issue(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF);
      @(negedge clock);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
      chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t5_rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("t5_rst_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      @(posedge clock);
      #1 chk("t5_post_rst_ready", 32'(req_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("t5_no_response", 32'(rsp_valid), 32'd0);
      end
      xact(1'b0, 16'h0030, 32'h0, 4'hF, rd, er, lat);
      chk("t5_prior_contents", rd, 32'h01020304);
      chk("t5_load_err", 32'(er), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
